fir_stream_driver: RTL and testbench

//  Host-side counterpart of the FIR filter sample handshake. Buffers upstream samples in a FIFO and

---
 rtl/fir_stream_driver_pkg.sv | 25 ++
 rtl/fir_sample_fifo.sv | 71 +++++++
 rtl/fir_stream_driver.sv | 199 +++++++++++++++++++
 tb/tb_fir_stream_driver.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_stream_driver_pkg.sv
// ----------------------------------------------------------------------------
// fir_stream_driver_pkg
// Shared definitions for the FIR stream driver: default parameter values,
// FSM state encodings and a helper that sizes the wait/timeout counter.
// No ports (package).
// ----------------------------------------------------------------------------
package fir_stream_driver_pkg;

  localparam int FSD_DATA_WIDTH     = 24;
  localparam int FSD_FIFO_DEPTH     = 16;
  localparam int FSD_MIN_LATENCY    = 18;
  localparam int FSD_TIMEOUT_CYCLES = 1024;

  typedef logic [1:0] fsd_state_t;

  localparam fsd_state_t ST_IDLE        = 2'd0;
  localparam fsd_state_t ST_SEND        = 2'd1;
  localparam fsd_state_t ST_WAIT_RESULT = 2'd2;

  // Bits needed for a counter that must be able to hold max_count.
  function automatic int fsd_cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// ----------------------------------------------------------------------------
// fir_sample_fifo
// Synchronous first-word-fall-through FIFO buffering upstream samples.
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_push            write iv_push_data (ignored while full)
//   iv_push_data      data to write
//   i_pop             drop the head entry (ignored while empty)
//   ov_head           current head entry (valid while !o_empty)
//   o_full, o_empty   occupancy flags
// ----------------------------------------------------------------------------
module fir_sample_fifo
  import fir_stream_driver_pkg::*;
#(
  parameter int DATA_WIDTH = FSD_DATA_WIDTH,
  parameter int FIFO_DEPTH = FSD_FIFO_DEPTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] iv_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] ov_head,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  w_push;
  logic                  w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign o_empty = (r_count == (AW+1)'(0));
  assign ov_head = r_mem[r_rd_ptr];

  // Storage array; contents need no reset because the count gates every read.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= iv_push_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= (AW+1)'(0);
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fir_stream_driver.sv
// ----------------------------------------------------------------------------
// fir_stream_driver
// Host-side driver for the FIR core sample handshake. Buffers upstream
// samples, issues them one at a time to the filter, collects each result after
// the minimum filter latency and forwards it on a valid/ready stream.
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_en                            global enable (low freezes FSM/counters/FIFO)
//   iv_s_data, i_s_valid, o_s_ready upstream sample stream
//   ov_fir_din, o_fir_din_valid     sample presented to the filter
//   i_fir_ready                     filter consumed the sample (pulse)
//   iv_fir_dout, i_fir_dout_valid   filter result (level valid)
//   o_fir_ready                     result acknowledge (one-cycle pulse)
//   ov_m_data, o_m_valid, i_m_ready result stream to the sink
//   ov_result_count                 results loaded into the output register
//   o_timeout                       sticky timeout flag
// ----------------------------------------------------------------------------
module fir_stream_driver
  import fir_stream_driver_pkg::*;
#(
  parameter int DATA_WIDTH     = FSD_DATA_WIDTH,
  parameter int FIFO_DEPTH     = FSD_FIFO_DEPTH,
  parameter int MIN_LATENCY    = FSD_MIN_LATENCY,
  parameter int TIMEOUT_CYCLES = FSD_TIMEOUT_CYCLES
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] iv_s_data,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  output logic [DATA_WIDTH-1:0] ov_fir_din,
  output logic                  o_fir_din_valid,
  input  logic                  i_fir_ready,
  input  logic [DATA_WIDTH-1:0] iv_fir_dout,
  input  logic                  i_fir_dout_valid,
  output logic                  o_fir_ready,
  output logic [DATA_WIDTH-1:0] ov_m_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [31:0]           ov_result_count,
  output logic                  o_timeout
);

  localparam int               CNT_W     = fsd_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] C_MIN_LAT = CNT_W'(MIN_LATENCY);
  localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  fsd_state_t            r_state;
  logic [CNT_W-1:0]      r_wait_cnt;
  logic [DATA_WIDTH-1:0] r_fir_din;
  logic                  r_fir_din_valid;
  logic                  r_fir_ready;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_valid;
  logic [31:0]           r_result_count;
  logic                  r_timeout;

  fsd_state_t            w_state_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_din_nxt;
  logic                  w_din_valid_nxt;
  logic                  w_timeout_set;
  logic                  w_capture;
  logic                  w_out_free;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [DATA_WIDTH-1:0] w_head;

  // Ready is qualified by reset so every output reads 0 while reset is held.
  assign o_s_ready  = !w_full && i_en && i_rst_n;
  assign w_push     = i_s_valid && o_s_ready;
  assign w_pop      = i_en && (r_state == ST_IDLE) && !w_empty;
  // The output register can take a new result if empty or draining this cycle.
  assign w_out_free = !r_m_valid || i_m_ready;
  assign w_capture  = i_en && (r_state == ST_WAIT_RESULT) && (r_wait_cnt >= C_MIN_LAT) &&
                      i_fir_dout_valid && w_out_free;

  fir_sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_push       (w_push),
    .iv_push_data (iv_s_data),
    .i_pop        (w_pop),
    .ov_head      (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

  // Next-state logic for the sample handshake FSM and its wait/timeout counter.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_wait_cnt;
    w_din_nxt       = r_fir_din;
    w_din_valid_nxt = r_fir_din_valid;
    w_timeout_set   = 1'b0;
    if (i_en) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            w_state_nxt     = ST_SEND;
            w_din_nxt       = w_head;
            w_din_valid_nxt = 1'b1;
            w_cnt_nxt       = CNT_W'(0);
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_SEND: begin
          // A consume pulse on the last allowed cycle still counts as consumed.
          if (i_fir_ready) begin
            w_state_nxt     = ST_WAIT_RESULT;
            w_din_valid_nxt = 1'b0;
            w_cnt_nxt       = CNT_W'(0);
          end else if (r_wait_cnt == C_TO_LAST) begin
            w_state_nxt     = ST_IDLE;
            w_din_valid_nxt = 1'b0;
            w_cnt_nxt       = CNT_W'(0);
            w_timeout_set   = 1'b1;
          end else begin
            w_cnt_nxt = r_wait_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_RESULT: begin
          if (w_capture) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = CNT_W'(0);
          end else if (r_wait_cnt == C_TO_LAST) begin
            w_state_nxt   = ST_IDLE;
            w_cnt_nxt     = CNT_W'(0);
            w_timeout_set = 1'b1;
          end else begin
            w_cnt_nxt = r_wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt     = ST_IDLE;
          w_din_valid_nxt = 1'b0;
          w_cnt_nxt       = CNT_W'(0);
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // FSM state, wait counter and the registered filter-side sample.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= ST_IDLE;
      r_wait_cnt      <= CNT_W'(0);
      r_fir_din       <= DATA_WIDTH'(0);
      r_fir_din_valid <= 1'b0;
      r_timeout       <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_wait_cnt      <= w_cnt_nxt;
      r_fir_din       <= w_din_nxt;
      r_fir_din_valid <= w_din_valid_nxt;
      r_timeout       <= r_timeout | w_timeout_set;
    end
  end

  // Result register, acknowledge pulse and delivered-result counter.
  // Draining via i_m_ready works regardless of i_en; loading needs i_en.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_m_data       <= DATA_WIDTH'(0);
      r_m_valid      <= 1'b0;
      r_fir_ready    <= 1'b0;
      r_result_count <= 32'd0;
    end else begin
      r_fir_ready <= w_capture;
      if (w_capture) begin
        r_m_data       <= iv_fir_dout;
        r_m_valid      <= 1'b1;
        r_result_count <= r_result_count + 32'd1;
      end else if (i_m_ready) begin
        r_m_valid <= 1'b0;
      end else begin
        r_m_valid <= r_m_valid;
      end
    end
  end

  assign ov_fir_din      = r_fir_din;
  assign o_fir_din_valid = r_fir_din_valid;
  assign o_fir_ready     = r_fir_ready;
  assign ov_m_data       = r_m_data;
  assign o_m_valid       = r_m_valid;
  assign ov_result_count = r_result_count;
  assign o_timeout       = r_timeout;

endmodule

// File: tb/tb_fir_stream_driver.sv
// ----------------------------------------------------------------------------
// tb_fir_stream_driver
// Self-checking bench: behavioural FIR model (consumes a sample, returns it
// doubled), scoreboard queue of expected results, monitor on the m stream.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ----------------------------------------------------------------------------
module tb_fir_stream_driver;

  localparam int DW     = 24;
  localparam int MINLAT = 18;
  localparam int TO     = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] fir_din;
  logic          fir_din_valid;
  logic          fir_rdy = 1'b0;
  logic [DW-1:0] fir_dout = '0;
  logic          fir_dout_vld = 1'b1;
  logic          ack;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [31:0]   result_count;
  logic          timeout;

  fir_stream_driver dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_en             (en),
    .iv_s_data        (s_data),
    .i_s_valid        (s_valid),
    .o_s_ready        (s_ready),
    .ov_fir_din       (fir_din),
    .o_fir_din_valid  (fir_din_valid),
    .i_fir_ready      (fir_rdy),
    .iv_fir_dout      (fir_dout),
    .i_fir_dout_valid (fir_dout_vld),
    .o_fir_ready      (ack),
    .ov_m_data        (m_data),
    .o_m_valid        (m_valid),
    .i_m_ready        (m_ready),
    .ov_result_count  (result_count),
    .o_timeout        (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rst_epoch = 0;
  always @(negedge rst_n) rst_epoch <= rst_epoch + 1;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];
  int n_expected = 0;

  // filter model controls
  bit fm_stall = 1'b0;
  bit fm_stuck = 1'b1;
  bit fm_busy  = 1'b0;
  int fm_lat   = 20;
  int ack_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic logic [DW-1:0] dbl(input logic [DW-1:0] x);
    return {x[DW-2:0], 1'b0};
  endfunction

  // Offer one sample upstream; record the expected result when accepted.
  task automatic push(input logic [DW-1:0] d, input bit expect_out);
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    s_data  = d;
    s_valid = 1'b1;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      if (s_ready) done = 1'b1;
    end
    if (done) begin
      if (expect_out) begin
        exp_q.push_back(dbl(d));
        n_expected++;
      end
    end else begin
      fail_now("push_accept");
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 5000 && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !fm_busy && !fir_din_valid && !m_valid) done = 1'b1;
    end
    if (!done) fail_now(name);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural FIR core: consumes a sample after a short delay and presents
  // the doubled sample; in stuck mode the result valid never drops.
  initial begin : filter_model
    logic [DW-1:0] first_seen;
    logic [DW-1:0] held;
    int            consume_cyc;
    int            ep;
    bit            seen;
    forever begin
      @(negedge clk);
      fir_dout_vld = fm_stuck;
      if (rst_n && fir_din_valid && !fm_stall) begin
        first_seen = fir_din;
        repeat (2) @(negedge clk);
        check("din_held_stable", 32'(fir_din), 32'(first_seen));
        @(posedge clk); #1;
        fir_rdy     = 1'b1;
        consume_cyc = cyc + 1;
        ep          = rst_epoch;
        fm_busy     = 1'b1;
        held        = fir_din;
        @(posedge clk); #1;
        fir_rdy  = 1'b0;
        fir_dout = dbl(held);
        if (!fm_stuck) begin
          for (int k = 0; k < fm_lat - 2 && rst_epoch == ep; k++) @(posedge clk);
          #1;
          if (rst_epoch == ep) fir_dout_vld = 1'b1;
        end
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen && rst_epoch == ep; k++) begin
          @(negedge clk);
          if (rst_n && ack) seen = 1'b1;
        end
        if (seen) begin
          ack_cnt++;
          if (fm_stuck) check("ack_latency_exact", 32'(cyc - consume_cyc), 32'(MINLAT + 1));
          else          check("ack_latency_min", 32'(cyc - consume_cyc >= MINLAT + 1), 32'd1);
        end else if (rst_epoch == ep) begin
          fail_now("ack_wait");
        end
        @(posedge clk); #1;
        if (!fm_stuck) fir_dout_vld = 1'b0;
        fm_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor on the result stream plus spurious-acknowledge watch.
  initial begin : monitor
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("m_unexpected_result");
        end else begin
          e = exp_q.pop_front();
          check("m_data", 32'(m_data), 32'(e));
        end
      end
      if (rst_n && ack && !fm_busy) begin
        n_checks++;
        n_errors++;
        $display("FAIL spurious_ack: got 1, expected 0 (t=%0t)", $time);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [DW-1:0] sample;
    logic [DW-1:0] expected;
  } vec_t;

  initial begin : main
    vec_t vecs[3];
    int   t0;
    int   base_ack;
    bit   done;
    vecs[0] = '{sample: 24'h000001, expected: 24'h000002};
    vecs[1] = '{sample: 24'h7FFFFF, expected: 24'hFFFFFE};
    vecs[2] = '{sample: 24'h800000, expected: 24'h000000};

    // Reset state
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_din_valid", 32'(fir_din_valid), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_count", result_count, 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_s_ready", 32'(s_ready), 32'd1);

    // Result valid stuck high from time 0: capture exactly MIN_LATENCY after consume
    push(24'h000011, 1'b1);
    push(24'h123456, 1'b1);
    wait_drain("drain_stuck");
    check("stuck_one_ack_per_sample", 32'(ack_cnt), 32'd2);
    check("stuck_count", result_count, 32'(n_expected));
    @(posedge clk); #1 fm_stuck = 1'b0;
    wait_cycles(2);

    // Table: three serial handshakes
    for (int i = 0; i < 3; i++) push(vecs[i].sample, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(vecs[i].expected);
      n_expected++;
    end
    wait_drain("drain_table");
    check("table_count", result_count, 32'd5);
    check("table_acks", 32'(ack_cnt), 32'd5);

    // FIFO fill while the filter stalls, then refill after one pop
    fm_stall = 1'b1;
    for (int i = 0; i < 17; i++) push(24'(32'h100 + i), 1'b1);
    @(negedge clk);
    check("fifo_full_ready_low", 32'(s_ready), 32'd0);
    fm_stall = 1'b0;
    push(24'h000200, 1'b1);
    @(negedge clk);
    check("fifo_refill_full", 32'(s_ready), 32'd0);
    wait_drain("drain_fifo");
    check("fifo_count", result_count, 32'(n_expected));

    // Sink back-pressure withholds the acknowledge of the second result
    @(posedge clk); #1 m_ready = 1'b0;
    base_ack = ack_cnt;
    push(24'h0ABCDE, 1'b1);
    push(24'h13579B, 1'b1);
    done = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk);
      if (ack_cnt == base_ack + 1 && !fm_busy) done = 1'b1;
    end
    if (!done) fail_now("bp_first_ack");
    done = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk);
      if (fm_busy && fir_dout_vld) done = 1'b1;
    end
    if (!done) fail_now("bp_second_ready");
    wait_cycles(30);
    check("bp_ack_withheld", 32'(ack_cnt), 32'(base_ack + 1));
    check("bp_m_valid_held", 32'(m_valid), 32'd1);
    check("bp_m_data_held", 32'(m_data), 32'h1579BC);
    @(posedge clk); #1 m_ready = 1'b1;
    @(posedge clk); #1 m_ready = 1'b0;
    @(negedge clk);
    check("bp_load_ack", 32'(ack), 32'd1);
    check("bp_load_valid", 32'(m_valid), 32'd1);
    check("bp_load_data", 32'(m_data), 32'h26AF36);
    @(posedge clk); #1 m_ready = 1'b1;
    wait_drain("drain_bp");

    // Filter never consumes: timeout after TIMEOUT_CYCLES in SEND
    fm_stall = 1'b1;
    push(24'h0DEAD0, 1'b0);
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (fir_din_valid) done = 1'b1;
    end
    if (!done) fail_now("to_send");
    t0 = cyc;
    check("to_din", 32'(fir_din), 32'h0DEAD0);
    wait_cycles(1000);
    check("to_not_early", 32'(timeout), 32'd0);
    check("to_valid_held", 32'(fir_din_valid), 32'd1);
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (timeout) done = 1'b1;
    end
    if (!done) fail_now("to_flag");
    check("to_cycles", 32'(cyc - t0), 32'(TO));
    check("to_valid_dropped", 32'(fir_din_valid), 32'd0);
    fm_stall = 1'b0;
    push(24'h000005, 1'b1);
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (fir_din_valid) done = 1'b1;
    end
    if (!done) fail_now("to_next_issue");
    check("to_next_din", 32'(fir_din), 32'h000005);
    wait_drain("drain_to");
    check("to_sticky", 32'(timeout), 32'd1);
    check("to_count", result_count, 32'(n_expected));

    // Asynchronous reset in the middle of WAIT_RESULT
    fm_lat = 200;
    push(24'h000077, 1'b1);
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (fm_busy) done = 1'b1;
    end
    if (!done) fail_now("ar_consume");
    wait_cycles(10);
    push(24'h000088, 1'b0);
    push(24'h000099, 1'b0);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("ar_s_ready", 32'(s_ready), 32'd0);
    check("ar_din", 32'(fir_din), 32'd0);
    check("ar_din_valid", 32'(fir_din_valid), 32'd0);
    check("ar_m_data", 32'(m_data), 32'd0);
    check("ar_m_valid", 32'(m_valid), 32'd0);
    check("ar_ack", 32'(ack), 32'd0);
    check("ar_count", result_count, 32'd0);
    check("ar_timeout", 32'(timeout), 32'd0);
    exp_q.delete();
    n_expected = 0;
    fm_lat = 20;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (fir_din_valid) done = 1'b1;
    end
    check("ar_fifo_empty", 32'(done), 32'd0);
    check("ar_ready_after", 32'(s_ready), 32'd1);

    // Enable low blocks upstream acceptance
    @(posedge clk); #1 en = 1'b0;
    @(negedge clk);
    check("en_low_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1 en = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
